multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle control unit for the RISC-V datapath. It decodes the current instruction fields, sequences them through a Moore FSM, and drives the existing ALU's `AluControl` input. It also drives the datapath mux selects and write enables, and resolves branches from the ALU `Zero`/`Signflag` outputs. It sits beside the datapath and is the producer side of the ALU control interface.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; forces FSM to FETCH.
- `op` in 7: instruction[6:0].
- `funct3` in 3: instruction[14:12].
- `funct7b5` in 1: instruction[30].
- `Zero` in 1: ALU zero flag.
- `Signflag` in 1: ALU result bit 31.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction/OldPC register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALU Result.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1 register A.
- `ALUSrcB` out 2: ALU B select. 00 = rs2 register B, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `AluControl` out 3: ALU operation code.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I-ALU 0010011
  - jal 1101111
  - branch 1100011
- FSM states and Moore outputs. Any output not listed is 0 or 00.
  - FETCH: IRWrite, ALUSrcB=10, ResultSrc=10, PCUpdate. Next state is DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch target. Next state by op:
    - lw/sw → MEMADR
    - R → EXECUTER
    - I → EXECUTEI
    - jal → JAL
    - branch → BRANCH
    - any other opcode → FETCH, treated as a NOP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1. Next state is MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next state is FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite. Next state is FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
  - ALUWB: RegWrite. Next state is FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate. Next state is ALUWB.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch. Next state is FETCH.
- PC write enable: `PCWrite = PCUpdate | (Branch & taken)`.
- Branch taken condition, by funct3:
  - 000 beq: taken if Zero.
  - 001 bne: taken if !Zero.
  - 100 blt: taken if Signflag, i.e. sign of A−B. Overflow is deliberately ignored.
  - 101 bge: taken if !Signflag.
  - Any other funct3: not taken.
- ALU decoder, ALUOp 00 → 000 (add), ALUOp 01 → 010 (sub).
- ALU decoder, ALUOp 10, selected by funct3:
  - 000: 010 (sub) only when op[5] & funct7b5, otherwise 000 (add).
  - 001: 001 (sll).
  - 100: 100 (xor).
  - 101: 101 (srl). sra/srai are executed as srl.
  - 110: 110 (or).
  - 111: 111 (and).
  - 010/011: 011. slt/sltu are unsupported; the ALU returns 0.
- ALUOp 11 is unused and decodes to 000.
- ImmSrc is purely combinational from op in every state:
  - sw → 01
  - branch → 10
  - jal → 11
  - all others → 00.

## Timing
- While reset is high, at the rising edge the state register loads FETCH.
- During the reset cycle, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. All other outputs show FETCH values: ALUSrcB=10, ResultSrc=10, AluControl=000.
- The first FETCH is the cycle after reset deasserts.
- Reset mid-instruction aborts the instruction with no register or memory write in the reset cycle.
- Cycles per instruction, FETCH inclusive:
  - lw 5
  - sw, R, I, jal 4
  - branch 3
  - unsupported opcode 2
- All outputs except PCWrite are functions of state and the instruction fields only.
- PCWrite in BRANCH also depends combinationally on the same-cycle Zero and Signflag.
- Instruction fields are stable from DECODE through the last state of the instruction. IR is loaded at the end of FETCH.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum
  - opcode constants
  - AluControl codes: ADD 000, SLL 001, SUB 010, XOR 100, SRL 101, OR 110, AND 111
  - ALUOp, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- Sub-module `alu_decoder`: combinational ALUOp/funct3/funct7b5/op[5] → AluControl. It is instantiated once and is reusable by a single-cycle control unit.
- The top level contains the state register, next-state logic, output decode, branch resolution and ImmSrc decode.

## Test plan
- Reset held 2 cycles then released:
  - PCWrite, IRWrite, RegWrite and MemWrite are 0 during reset.
  - The cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- R-type sub, op=0110011, funct3=000, funct7b5=1:
  - State sequence FETCH, DECODE, EXECUTER, ALUWB.
  - AluControl=010 in EXECUTER.
  - RegWrite=1 only in ALUWB.
- addi with funct7b5=1 (immediate bit): AluControl=000 in EXECUTEI, not sub.
- lw: 5-cycle sequence with AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB.
- sw: MemWrite=1 only in MEMWRITE, ImmSrc=01 throughout, back to FETCH after 4 cycles.
- Branches in the BRANCH state, with ImmSrc=10:
  - beq with Zero=1: PCWrite=1.
  - beq with Zero=0: PCWrite=0.
  - blt with Signflag=1: PCWrite=1.
  - bge with Signflag=1: PCWrite=0.
- op=0110111 (lui, unsupported): DECODE → FETCH with no writes.
- Reset asserted in MEMWRITE: MemWrite=0 that cycle and FETCH next.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path:
// FSM states, opcodes, ALU codes and datapath mux selects.
package riscv_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JAL      = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // blt/bge use the raw sign of A-B; overflow is ignored.
  function automatic logic branch_taken(
    input logic [2:0] funct3,
    input logic       zero,
    input logic       sign
  );
    logic t;
    t = 1'b0;
    case (funct3)
      3'b000:  t = zero;
      3'b001:  t = ~zero;
      3'b100:  t = sign;
      3'b101:  t = ~sign;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/funct3/funct7b5/op[5] -> AluControl decoder.
// Ports: alu_op, funct3, funct7b5, op5 in; alu_control out.
import riscv_pkg::*;

module alu_decoder (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 is an immediate bit for I-type, so
          // only R-type (op[5]=1) may select sub.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB
                                                  : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_SLT;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM multicycle control unit for the RISC-V datapath.
// Ports: clk, reset, op/funct3/funct7b5, Zero/Signflag in;
//        PC/mem/IR/reg enables, mux selects, ImmSrc, AluControl out.
import riscv_pkg::*;

module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Signflag,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] AluControl
);

  state_t state_q;
  state_t state_d;
  state_t cur;
  ctrl_t  ctrl;
  logic   taken;

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):     state_d = S_MEMADR;
          (op == OP_R):      state_d = S_EXECUTER;
          (op == OP_I):      state_d = S_EXECUTEI;
          (op == OP_JAL):    state_d = S_JAL;
          (op == OP_BRANCH): state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR; op[5] separates them.
      S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    if (reset) state_d = S_FETCH;
  end

  // Reset cycle shows FETCH decode; write enables masked below.
  assign cur = reset ? S_FETCH : state_q;

  always_comb begin
    ctrl = '0;
    case (cur)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_JAL: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_update = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign taken = branch_taken(funct3, Zero, Signflag);

  assign PCWrite = ~reset
                 & (ctrl.pc_update | (ctrl.branch & taken));
  assign IRWrite   = ~reset & ctrl.ir_write;
  assign RegWrite  = ~reset & ctrl.reg_write;
  assign MemWrite  = ~reset & ctrl.mem_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;

  always_comb begin
    ImmSrc = IMM_I;
    unique case (1'b1)
      (op == OP_SW):     ImmSrc = IMM_S;
      (op == OP_BRANCH): ImmSrc = IMM_B;
      (op == OP_JAL):    ImmSrc = IMM_J;
      default:           ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (AluControl)
  );

endmodule
